music_seq: RTL and testbench

MUSIC_SEQ -- requirements
Module: music_seq

---
 rtl/music_pkg.sv | 38 +++
 rtl/music_rom.sv | 52 +++++
 rtl/music_seq.sv | 156 +++++++++++++++
 tb/tb_music_seq.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/music_pkg.sv
// Shared definitions for the music sequencer: note codes, ROM entry layout and FSM states.
package music_pkg;

  localparam int NOTE_W_DEF = 5;
  localparam int DUR_W_DEF  = 3;

  // Scale degrees: low octave 1..7, middle 8..14, high 15..21; 0 is silence.
  localparam int REST = 0;
  localparam int L1 = 1;
  localparam int L2 = 2;
  localparam int L3 = 3;
  localparam int L4 = 4;
  localparam int L5 = 5;
  localparam int L6 = 6;
  localparam int L7 = 7;
  localparam int M1 = 8;
  localparam int M2 = 9;
  localparam int M3 = 10;
  localparam int M4 = 11;
  localparam int M5 = 12;
  localparam int M6 = 13;
  localparam int M7 = 14;
  localparam int H1 = 15;
  localparam int H2 = 16;
  localparam int H3 = 17;
  localparam int H4 = 18;
  localparam int H5 = 19;
  localparam int H6 = 20;
  localparam int H7 = 21;

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, PLAY, DONE} state_e;

  // An entry is {eos, dur, note}.
  function automatic int entryWidth(input int noteW, input int durW);
    return 1 + durW + noteW;
  endfunction

endpackage

// File: rtl/music_rom.sv
// Song table for music_seq: synchronous-read case ROM indexed by {song, index}.
// Unlisted addresses read as 0, which plays as a one-beat rest with no end marker.
module music_rom
  import music_pkg::*;
#(
  parameter int NOTE_W = NOTE_W_DEF,
  parameter int DUR_W  = DUR_W_DEF,
  parameter int ADDR_W = 6,
  parameter int SEL_W  = 2
) (
  input  logic                                 clk,
  input  logic [SEL_W+ADDR_W-1:0]              addr_i,
  output logic [entryWidth(NOTE_W, DUR_W)-1:0] data_o
);

  localparam int ENTRY_W = entryWidth(NOTE_W, DUR_W);
  localparam int DEPTH   = 2 ** ADDR_W;

  logic [ENTRY_W-1:0] romD;
  logic [ENTRY_W-1:0] data_q;

  function automatic logic [ENTRY_W-1:0] ent(input logic eos, input int dur, input int nt);
    return {eos, DUR_W'(dur), NOTE_W'(nt)};
  endfunction

  // Song 1 has no end marker at all, so it wraps through every slot.
  always_comb begin
    romD = '0;
    case (int'(addr_i))
      0 * DEPTH + 0:         romD = ent(1'b0, 2, M6);
      0 * DEPTH + 1:         romD = ent(1'b0, 1, M5);
      0 * DEPTH + 2:         romD = ent(1'b1, 0, REST);
      1 * DEPTH + 0:         romD = ent(1'b0, 1, H1);
      1 * DEPTH + 1:         romD = ent(1'b0, 2, M3);
      1 * DEPTH + DEPTH - 1: romD = ent(1'b0, 1, L1);
      2 * DEPTH + 0:         romD = ent(1'b0, 1, L5);
      2 * DEPTH + 1:         romD = ent(1'b0, 0, L5);
      2 * DEPTH + 2:         romD = ent(1'b0, 3, H7);
      2 * DEPTH + 3:         romD = ent(1'b1, 0, REST);
      3 * DEPTH + 0:         romD = ent(1'b0, 1, H2);
      3 * DEPTH + 1:         romD = ent(1'b1, 0, REST);
      default:               romD = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    data_q <= romD;
  end

  assign data_o = data_q;

endmodule

// File: rtl/music_seq.sv
// Music sequencer: walks a song in music_rom and presents one note code per entry.
// Define MUSIC_SEQ_ARTIC_EN to silence the tail of each entry for a staccato gap.
module music_seq
  import music_pkg::*;
#(
  parameter int NOTE_W   = NOTE_W_DEF,
  parameter int DUR_W    = DUR_W_DEF,
  parameter int ADDR_W   = 6,
  parameter int SONGS    = 4,
  parameter int BEAT_DIV = 12_500_000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     play,
  input  logic                     stop,
  input  logic                     pause,
  input  logic                     loop_en,
  input  logic [$clog2(SONGS)-1:0] song_sel,
  output logic [NOTE_W-1:0]        note,
  output logic                     busy,
  output logic                     beat_pulse,
  output logic                     song_done
);

  localparam int SEL_W   = $clog2(SONGS);
  localparam int CNT_W   = $clog2(BEAT_DIV);
  localparam int ENTRY_W = entryWidth(NOTE_W, DUR_W);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   song_q, song_d, songPick;
  logic [ADDR_W-1:0]  index_q, index_d;
  logic [NOTE_W-1:0]  note_q, note_d;
  logic [CNT_W-1:0]   beatCnt_q, beatCnt_d;
  logic [DUR_W-1:0]   beatLeft_q, beatLeft_d;
  logic [ENTRY_W-1:0] romData;
  logic               romEos;
  logic [DUR_W-1:0]   romDur;
  logic [NOTE_W-1:0]  romNote;
  logic               playing, beatEnd, lastBeat, inGap;

  music_rom #(
    .NOTE_W (NOTE_W),
    .DUR_W  (DUR_W),
    .ADDR_W (ADDR_W),
    .SEL_W  (SEL_W)
  ) u_rom (
    .clk    (clk),
    .addr_i ({song_q, index_q}),
    .data_o (romData)
  );

  assign {romEos, romDur, romNote} = romData;

  assign playing  = (state_q == PLAY) && !pause;
  assign beatEnd  = playing && (beatCnt_q == CNT_W'(BEAT_DIV - 1));
  assign lastBeat = (beatLeft_q == DUR_W'(1));

`ifdef MUSIC_SEQ_ARTIC_EN
  localparam int GAP = BEAT_DIV / 8;
  assign inGap = lastBeat && (int'(beatCnt_q) >= BEAT_DIV - GAP);
`else
  assign inGap = 1'b0;
`endif

  always_comb begin
    songPick = song_sel;
    if (int'(song_sel) >= SONGS) songPick = SEL_W'(SONGS - 1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (stop) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (play) state_d = FETCH;
        FETCH:   state_d = WAIT;
        WAIT:    state_d = !romEos ? PLAY : (loop_en ? FETCH : DONE);
        PLAY:    if (beatEnd && lastBeat) state_d = FETCH;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Pause simply stops the beat counter; the held count resumes on release.
  always_comb begin
    song_d     = song_q;
    index_d    = index_q;
    note_d     = note_q;
    beatCnt_d  = beatCnt_q;
    beatLeft_d = beatLeft_q;
    if (stop) begin
      index_d   = '0;
      beatCnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (play) begin
            song_d  = songPick;
            index_d = '0;
          end
        end
        WAIT: begin
          if (!romEos) begin
            note_d     = romNote;
            beatLeft_d = (romDur == '0) ? DUR_W'(1) : romDur;
            beatCnt_d  = '0;
          end else if (loop_en) begin
            index_d = '0;
          end
        end
        PLAY: begin
          if (beatEnd) begin
            beatCnt_d = '0;
            if (lastBeat) index_d = index_q + ADDR_W'(1);
            else          beatLeft_d = beatLeft_q - DUR_W'(1);
          end else if (playing) begin
            beatCnt_d = beatCnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      song_q     <= '0;
      index_q    <= '0;
      note_q     <= '0;
      beatCnt_q  <= '0;
      beatLeft_q <= '0;
    end else begin
      song_q     <= song_d;
      index_q    <= index_d;
      note_q     <= note_d;
      beatCnt_q  <= beatCnt_d;
      beatLeft_q <= beatLeft_d;
    end
  end

  always_comb begin
    busy       = (state_q != IDLE);
    song_done  = (state_q == DONE);
    beat_pulse = beatEnd;
    note       = '0;
    if (playing && !inGap) note = note_q;
  end

endmodule

// File: tb/tb_music_seq.sv
// Testbench for music_seq: a timeline model of the songs checked every cycle,
// plus directed scenarios with hand-counted expectations and a randomized phase.
module tb_music_seq;

  localparam int BD     = 4;
  localparam int SONGS  = 3;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 64;
`ifdef MUSIC_SEQ_ARTIC_EN
  localparam int TB_GAP = BD / 8;
`else
  localparam int TB_GAP = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       play = 1'b0, stop = 1'b0, pause = 1'b0, loop_en = 1'b0;
  logic [1:0] song_sel = 2'd0;
  logic [4:0] note;
  logic       busy, beat_pulse, song_done;

  int vectors = 0;
  int miscompares = 0;

  music_seq #(
    .NOTE_W   (5),
    .DUR_W    (3),
    .ADDR_W   (ADDR_W),
    .SONGS    (SONGS),
    .BEAT_DIV (BD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .play       (play),
    .stop       (stop),
    .pause      (pause),
    .loop_en    (loop_en),
    .song_sel   (song_sel),
    .note       (note),
    .busy       (busy),
    .beat_pulse (beat_pulse),
    .song_done  (song_done)
  );

  always #5 clk = ~clk;

  // The songs as written down on paper: note code, beats, end marker.
  int romNote [4][DEPTH];
  int romDur  [4][DEPTH];
  bit romEos  [4][DEPTH];

  initial begin
    for (int s = 0; s < 4; s++)
      for (int i = 0; i < DEPTH; i++) begin
        romNote[s][i] = 0;
        romDur[s][i]  = 0;
        romEos[s][i]  = 1'b0;
      end
    romNote[0][0] = 13; romDur[0][0] = 2;
    romNote[0][1] = 12; romDur[0][1] = 1;
    romEos[0][2]  = 1'b1;
    romNote[1][0] = 15; romDur[1][0] = 1;
    romNote[1][1] = 10; romDur[1][1] = 2;
    romNote[1][63] = 1; romDur[1][63] = 1;
    romNote[2][0] = 5;  romDur[2][0] = 1;
    romNote[2][1] = 5;  romDur[2][1] = 0;
    romNote[2][2] = 21; romDur[2][2] = 3;
    romEos[2][3]  = 1'b1;
    romNote[3][0] = 16; romDur[3][0] = 1;
    romEos[3][1]  = 1'b1;
  end

  // Timeline model: after a start there are two silent set-up cycles per entry,
  // then the note sounds for dur*BD unpaused cycles.
  bit mActive = 1'b0;
  bit mDone   = 1'b0;
  int mPrep   = 0;
  int mSong   = 0;
  int mIdx    = 0;
  int mPlayed = 0;
  int mLen    = 0;
  int mNote   = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mActive <= 1'b0;
      mDone   <= 1'b0;
      mPrep   <= 0;
      mIdx    <= 0;
      mPlayed <= 0;
    end else if (stop) begin
      mActive <= 1'b0;
      mDone   <= 1'b0;
    end else if (mDone) begin
      mActive <= 1'b0;
      mDone   <= 1'b0;
    end else if (!mActive) begin
      if (play) begin
        mActive <= 1'b1;
        mSong   <= (int'(song_sel) >= SONGS) ? SONGS - 1 : int'(song_sel);
        mIdx    <= 0;
        mPrep   <= 2;
      end
    end else if (mPrep == 2) begin
      mPrep <= 1;
    end else if (mPrep == 1) begin
      if (!romEos[mSong][mIdx]) begin
        mNote   <= romNote[mSong][mIdx];
        mLen    <= ((romDur[mSong][mIdx] == 0) ? 1 : romDur[mSong][mIdx]) * BD;
        mPlayed <= 0;
        mPrep   <= 0;
      end else if (loop_en) begin
        mIdx  <= 0;
        mPrep <= 2;
      end else begin
        mDone <= 1'b1;
      end
    end else if (!pause) begin
      mPlayed <= mPlayed + 1;
      if (mPlayed + 1 == mLen) begin
        mIdx  <= (mIdx + 1) % DEPTH;
        mPrep <= 2;
      end
    end
  end

  function automatic bit mSounding();
    return mActive && !mDone && (mPrep == 0);
  endfunction

  function automatic int expNote(input bit p);
    if (mSounding() && !p && (mPlayed < mLen - TB_GAP)) return mNote;
    return 0;
  endfunction

  function automatic int expPulse(input bit p);
    return (mSounding() && !p && ((mPlayed + 1) % BD == 0)) ? 1 : 0;
  endfunction

  task automatic checkOutput(input string name, input int act, input int want);
    vectors++;
    if (act != want) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at t=%0t", name, act, want, $time);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("note", int'(note), expNote(pause));
    checkOutput("busy", int'(busy), mActive ? 1 : 0);
    checkOutput("beat_pulse", int'(beat_pulse), expPulse(pause));
    checkOutput("song_done", int'(song_done), mDone ? 1 : 0);
  end

  // Cumulative output counters; scenarios compare differences of snapshots.
  int cnt13 = 0, cnt12 = 0, cntDone = 0, cntPulse = 0, cntPausedOut = 0;

  always @(negedge clk) begin
    if (note == 5'd13) cnt13 <= cnt13 + 1;
    if (note == 5'd12) cnt12 <= cnt12 + 1;
    if (song_done) cntDone <= cntDone + 1;
    if (beat_pulse) cntPulse <= cntPulse + 1;
    if (pause && (beat_pulse || note != 5'd0)) cntPausedOut <= cntPausedOut + 1;
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input bit p, input bit s, input int sel);
    play     = p;
    stop     = s;
    song_sel = 2'(sel);
    @(posedge clk);
    #1;
    play = 1'b0;
    stop = 1'b0;
  endtask

  task automatic waitForNote(input int target, input int budget, input string name);
    int n = 0;
    while (int'(note) != target && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput(name, int'(note), target);
  endtask

  task automatic waitForNew(input int exclude, input int budget, input int want, input string name);
    int n = 0;
    while ((note == 5'd0 || int'(note) == exclude) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput(name, int'(note), want);
  endtask

  initial begin
    #200_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int b13, b12, bDone, bPulse, bPaused;

    #1 rst = 1'b1;
    #2;
    checkOutput("reset_note", int'(note), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_pulse", int'(beat_pulse), 0);
    checkOutput("reset_done", int'(song_done), 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    cycles(2);

    // Song 0 once: 8 cycles of M6, 4 of M5, one done pulse.
    b13 = cnt13; b12 = cnt12; bDone = cntDone; bPulse = cntPulse;
    applyStimulus(1'b1, 1'b0, 0);
    cycles(25);
    checkOutput("song0_m6_cycles", cnt13 - b13, 8);
    checkOutput("song0_m5_cycles", cnt12 - b12, 4);
    checkOutput("song0_done_pulses", cntDone - bDone, 1);
    checkOutput("song0_beat_pulses", cntPulse - bPulse, 3);
    checkOutput("song0_idle_busy", int'(busy), 0);

    // Looping: back to M6 after M5 with no done pulse.
    loop_en = 1'b1;
    bDone = cntDone;
    applyStimulus(1'b1, 1'b0, 0);
    waitForNote(12, 30, "loop_reach_m5");
    waitForNote(13, 12, "loop_back_to_m6");
    waitForNote(12, 30, "loop_second_m5");
    checkOutput("loop_no_done", cntDone - bDone, 0);
    applyStimulus(1'b0, 1'b1, 0);
    loop_en = 1'b0;
    cycles(2);

    // Pause for 5 cycles in the middle of M6.
    b13 = cnt13; bDone = cntDone; bPaused = cntPausedOut;
    applyStimulus(1'b1, 1'b0, 0);
    waitForNote(13, 10, "pause_m6_start");
    cycles(3);
    pause = 1'b1;
    cycles(5);
    pause = 1'b0;
    cycles(30);
    checkOutput("pause_m6_audible", cnt13 - b13, 8);
    checkOutput("pause_silent_outputs", cntPausedOut - bPaused, 0);
    checkOutput("pause_done_pulses", cntDone - bDone, 1);

    // Stop and play together while playing.
    applyStimulus(1'b1, 1'b0, 0);
    waitForNote(13, 10, "stop_m6_start");
    applyStimulus(1'b1, 1'b1, 0);
    checkOutput("stop_busy", int'(busy), 0);
    checkOutput("stop_note", int'(note), 0);
    cycles(4);
    checkOutput("stop_no_restart", int'(busy), 0);

    // Asynchronous reset between edges, then a fresh start from index 0.
    applyStimulus(1'b1, 1'b0, 0);
    waitForNote(13, 10, "rst_m6_start");
    cycles(2);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_note", int'(note), 0);
    checkOutput("async_rst_busy", int'(busy), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    cycles(1);
    applyStimulus(1'b1, 1'b0, 0);
    waitForNew(0, 10, 13, "restart_first_note");
    applyStimulus(1'b0, 1'b1, 0);
    cycles(1);

    // Song 1 has no end marker: slot 63 (L1) is followed by slot 0 (H1).
    bDone = cntDone;
    applyStimulus(1'b1, 1'b0, 1);
    waitForNote(1, 600, "wrap_reach_slot63");
    waitForNew(1, 20, 15, "wrap_back_to_slot0");
    checkOutput("wrap_no_done", cntDone - bDone, 0);
    checkOutput("wrap_still_busy", int'(busy), 1);
    applyStimulus(1'b0, 1'b1, 0);
    cycles(1);

    // song_sel beyond the last song selects the last song (song 2 starts on L5).
    applyStimulus(1'b1, 1'b0, 3);
    waitForNew(0, 10, 5, "clamp_first_note");
    cycles(30);
    checkOutput("clamp_song_finished", int'(busy), 0);

    // Randomized control traffic, checked cycle by cycle against the model.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      rst      = 1'b0;
      play     = ($urandom_range(0, 15) == 0);
      stop     = ($urandom_range(0, 79) == 0);
      song_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) pause = ~pause;
      if ($urandom_range(0, 49) == 0) loop_en = ~loop_en;
      if ($urandom_range(0, 599) == 0) begin
        #2 rst = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0; play = 1'b0; stop = 1'b0; pause = 1'b0; loop_en = 1'b0;
    cycles(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
